// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Shared types and geometry defaults for the yellow moving
//               board (lever-controlled platform).
//               - board_state_t : board motion state encoding
//               - c_* constants : default geometry used as parameter defaults
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

    typedef enum logic [1:0] {
        UP_REST   = 2'd0,
        MOV_DOWN  = 2'd1,
        DOWN_REST = 2'd2,
        MOV_UP    = 2'd3
    } board_state_t;

    localparam logic [9:0] c_Y_UP    = 10'd270;
    localparam logic [9:0] c_Y_DOWN  = 10'd330;
    localparam logic [2:0] c_STEP    = 3'd4;
    localparam logic [9:0] c_X_LEFT  = 10'd20;
    localparam logic [9:0] c_X_RIGHT = 10'd120;
    localparam logic [6:0] c_BOARD_H = 7'd8;

endpackage : board_pkg
`default_nettype wire

// File: rtl/board_contact_det.sv
`default_nettype none
// ============================================================================
// Module      : board_contact_det
// Description : Combinational geometry test between the character box and
//               the board.
//   Ports:
//     char_x, char_y          in  10  character centre
//     char_width, char_height in  7   character size
//     board_y                 in  10  board top edge
//     step_d                  in  10  pending downward step size
//     h_overlap               out 1   character span intersects [X_LEFT, X_RIGHT)
//     on_top                  out 1   character bottom equals board top
//     below_gap               out 1   character top lies within the strip the
//                                     board underside would sweep this step
// Revision    : 1.0 - initial release
// ============================================================================
module board_contact_det
    import board_pkg::*;
#(
    parameter logic [9:0] X_LEFT  = c_X_LEFT,
    parameter logic [9:0] X_RIGHT = c_X_RIGHT,
    parameter logic [6:0] BOARD_H = c_BOARD_H
) (
    input  logic [9:0] char_x,
    input  logic [9:0] char_y,
    input  logic [6:0] char_width,
    input  logic [6:0] char_height,
    input  logic [9:0] board_y,
    input  logic [9:0] step_d,
    output logic       h_overlap,
    output logic       on_top,
    output logic       below_gap
);

    logic [9:0] w_half_w;
    logic [9:0] w_half_h;
    logic [9:0] w_left;
    logic [9:0] w_right;
    logic [9:0] w_top;
    logic [9:0] w_bot;
    logic [9:0] w_board_bot;

    // All geometry is plain 10-bit unsigned arithmetic on zero-extended sizes.
    assign w_half_w    = {3'b000, char_width} >> 1;
    assign w_half_h    = {3'b000, char_height} >> 1;
    assign w_left      = char_x - w_half_w;
    assign w_right     = char_x + w_half_w;
    assign w_top       = char_y - w_half_h;
    assign w_bot       = char_y + w_half_h;
    assign w_board_bot = board_y + {3'b000, BOARD_H};

    assign h_overlap = (w_left < X_RIGHT) && (w_right >= X_LEFT);
    assign on_top    = (w_bot == board_y);
    assign below_gap = (w_top >= w_board_bot) && (w_top < (w_board_bot + step_d));

endmodule : board_contact_det
`default_nettype wire

// File: rtl/yellow_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : yellow_board_ctrl
// Description : Moves the yellow board between its raised and lowered rest
//               positions, one step per frame tick, following the pole
//               detector's request level. Reports position, status and
//               character contact.
//   Ports:
//     Clk, Reset (async, active-high), frame_tick, board_down_req
//     char_x, char_y, char_width, char_height  - character box
//     board_y, board_moving, board_at_top, board_at_bottom, board_blocked
//     char_on_board, carry_dy (signed), carry_valid
//   Optional feature macro: BOARD_CARRY_EN (rider displacement outputs);
//   when undefined carry_dy / carry_valid are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module yellow_board_ctrl
    import board_pkg::*;
#(
    parameter logic [9:0] Y_UP    = c_Y_UP,
    parameter logic [9:0] Y_DOWN  = c_Y_DOWN,
    parameter logic [2:0] STEP    = c_STEP,
    parameter logic [9:0] X_LEFT  = c_X_LEFT,
    parameter logic [9:0] X_RIGHT = c_X_RIGHT,
    parameter logic [6:0] BOARD_H = c_BOARD_H
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              board_down_req,
    input  logic [9:0]        char_x,
    input  logic [9:0]        char_y,
    input  logic [6:0]        char_width,
    input  logic [6:0]        char_height,
    output logic [9:0]        board_y,
    output logic              board_moving,
    output logic              board_at_top,
    output logic              board_at_bottom,
    output logic              board_blocked,
    output logic              char_on_board,
    output logic signed [3:0] carry_dy,
    output logic              carry_valid
);

    board_state_t      r_state;
    board_state_t      w_state_nxt;
    logic [9:0]        r_board_y;
    logic [9:0]        w_board_y_nxt;
    logic              r_moving;
    logic              r_at_top;
    logic              r_at_bottom;
    logic              r_blocked;
    logic              w_blocked_nxt;
    logic              w_stepped;
    logic signed [3:0] w_step_dy;

    logic [9:0] w_step_ext;
    logic [9:0] w_rem_down;
    logic [9:0] w_rem_up;
    logic [9:0] w_d_down;
    logic [9:0] w_d_up;
    logic       w_h_overlap;
    logic       w_on_top;
    logic       w_below_gap;
    logic       w_char_on_board;

    // Step clipped to the remaining distance so a rest position is never overshot.
    assign w_step_ext = {7'd0, STEP};
    assign w_rem_down = Y_DOWN - r_board_y;
    assign w_rem_up   = r_board_y - Y_UP;
    assign w_d_down   = (w_rem_down < w_step_ext) ? w_rem_down : w_step_ext;
    assign w_d_up     = (w_rem_up   < w_step_ext) ? w_rem_up   : w_step_ext;

    board_contact_det #(
        .X_LEFT  (X_LEFT),
        .X_RIGHT (X_RIGHT),
        .BOARD_H (BOARD_H)
    ) u_contact (
        .char_x      (char_x),
        .char_y      (char_y),
        .char_width  (char_width),
        .char_height (char_height),
        .board_y     (r_board_y),
        .step_d      (w_d_down),
        .h_overlap   (w_h_overlap),
        .on_top      (w_on_top),
        .below_gap   (w_below_gap)
    );

    assign w_char_on_board = w_h_overlap && w_on_top;

    always_comb begin
        w_state_nxt   = r_state;
        w_board_y_nxt = r_board_y;
        w_blocked_nxt = 1'b0;
        w_stepped     = 1'b0;
        w_step_dy     = 4'sd0;
        case (r_state)
            UP_REST: begin
                if (board_down_req) w_state_nxt = MOV_DOWN;
            end
            DOWN_REST: begin
                if (!board_down_req) w_state_nxt = MOV_UP;
            end
            MOV_DOWN: begin
                if (!board_down_req) begin
                    w_state_nxt = MOV_UP;
                end else if (w_h_overlap && w_below_gap) begin
                    // Character is just beneath the board: hold position.
                    w_blocked_nxt = 1'b1;
                end else begin
                    w_board_y_nxt = r_board_y + w_d_down;
                    w_stepped     = 1'b1;
                    w_step_dy     = $signed({1'b0, w_d_down[2:0]});
                    if (w_d_down == w_rem_down) w_state_nxt = DOWN_REST;
                end
            end
            MOV_UP: begin
                if (board_down_req) begin
                    w_state_nxt = MOV_DOWN;
                end else begin
                    w_board_y_nxt = r_board_y - w_d_up;
                    w_stepped     = 1'b1;
                    w_step_dy     = -$signed({1'b0, w_d_up[2:0]});
                    if (w_d_up == w_rem_up) w_state_nxt = UP_REST;
                end
            end
            default: w_state_nxt = UP_REST;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= UP_REST;
            r_board_y   <= Y_UP;
            r_moving    <= 1'b0;
            r_at_top    <= 1'b1;
            r_at_bottom <= 1'b0;
            r_blocked   <= 1'b0;
        end else if (frame_tick) begin
            r_state     <= w_state_nxt;
            r_board_y   <= w_board_y_nxt;
            r_moving    <= (w_state_nxt == MOV_DOWN) || (w_state_nxt == MOV_UP);
            r_at_top    <= (w_state_nxt == UP_REST);
            r_at_bottom <= (w_state_nxt == DOWN_REST);
            r_blocked   <= w_blocked_nxt;
        end
    end

    assign board_y         = r_board_y;
    assign board_moving    = r_moving;
    assign board_at_top    = r_at_top;
    assign board_at_bottom = r_at_bottom;
    assign board_blocked   = r_blocked;
    assign char_on_board   = w_char_on_board;

`ifdef BOARD_CARRY_EN
    logic              r_carry_valid;
    logic signed [3:0] r_carry_dy;

    // Rider displacement pulses with the board_y update when the character
    // was standing on the board before the step.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_carry_valid <= 1'b0;
            r_carry_dy    <= 4'sd0;
        end else if (frame_tick && w_stepped && w_char_on_board) begin
            r_carry_valid <= 1'b1;
            r_carry_dy    <= w_step_dy;
        end else begin
            r_carry_valid <= 1'b0;
            r_carry_dy    <= 4'sd0;
        end
    end

    assign carry_valid = r_carry_valid;
    assign carry_dy    = r_carry_dy;
`else
    logic w_unused_rider;
    assign w_unused_rider = ^{w_stepped, w_step_dy};
    assign carry_valid    = 1'b0;
    assign carry_dy       = 4'sd0;
`endif

endmodule : yellow_board_ctrl
`default_nettype wire
